// File: rtl/fir_pkg.sv
// Shared FIR definitions: default geometry and the coefficient-loader FSM states.
// Imported by the loader, the filter and the benches.
package fir_pkg;

    localparam int NTAPS_DEF = 2048;
    localparam int CW_DEF    = 20;
    localparam int AW_DEF    = 11;
    localparam int PACE_DEF  = 10;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        GAP,
        DONE
    } fir_state_t;

endpackage

// File: rtl/fir_pace_timer.sv
// Loadable down-counter that sets the gap between coefficient strobes.
// zero: count is 0; last: count is 1, so the next decrement reaches 0.
module fir_pace_timer #(
    parameter int W = 4
) (
    input  logic         clk_fast,
    input  logic         resetn,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero,
    output logic         last
);

    logic [W-1:0] count;

    always_ff @(posedge clk_fast) begin
        if (!resetn) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);
    assign last = (count == W'(1));

endmodule

// File: rtl/fir_coef_loader.sv
// Streams NTAPS coefficients into fir_filter, one CLOAD every PACE cycles.
// Optional FIR_COEF_CHECKSUM_EN adds a csum output summing the loaded coefficients.
module fir_coef_loader
    import fir_pkg::*;
#(
    parameter int NTAPS = NTAPS_DEF,
    parameter int CW    = CW_DEF,
    parameter int AW    = AW_DEF,
    parameter int PACE  = PACE_DEF
) (
    input  logic          clk_fast,
    input  logic          resetn,
    input  logic          start,
    input  logic          s_valid,
    input  logic [CW-1:0] s_data,
    output logic          s_ready,
    output logic [CW-1:0] CIN,
    output logic [AW-1:0] CADDR,
    output logic          CLOAD,
    output logic          valid_in,
    output logic          filt_resetn,
    output logic          busy,
    output logic          done
`ifdef FIR_COEF_CHECKSUM_EN
    ,
    output logic [CW+AW-1:0] csum
`endif
);

    localparam int TW = (PACE > 2) ? $clog2(PACE) : 1;

    fir_state_t    state;
    logic [AW-1:0] addr;
    logic          hs;
    logic          last_tap;
    logic          tmr_load;
    logic          tmr_zero;
    logic          tmr_last;
    logic          gap_end;

    assign hs       = s_valid & s_ready;
    assign last_tap = (addr == AW'(NTAPS - 1));
    assign tmr_load = (state == FETCH) & hs;
    // The final tap waits a full pace period so the filter settles before release.
    assign gap_end  = last_tap ? tmr_zero : tmr_last;

    fir_pace_timer #(
        .W(TW)
    ) u_pace (
        .clk_fast (clk_fast),
        .resetn   (resetn),
        .load     (tmr_load),
        .load_val (TW'(PACE - 1)),
        .zero     (tmr_zero),
        .last     (tmr_last)
    );

    always_ff @(posedge clk_fast) begin
        if (!resetn) begin
            state       <= IDLE;
            addr        <= '0;
            s_ready     <= 1'b0;
            CIN         <= '0;
            CADDR       <= '0;
            CLOAD       <= 1'b0;
            valid_in    <= 1'b0;
            filt_resetn <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            CLOAD    <= 1'b0;
            valid_in <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state       <= FETCH;
                        addr        <= '0;
                        s_ready     <= 1'b1;
                        filt_resetn <= 1'b0;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                    end
                end
                FETCH: begin
                    if (hs) begin
                        CIN      <= s_data;
                        CADDR    <= addr;
                        CLOAD    <= 1'b1;
                        valid_in <= 1'b1;
                        s_ready  <= 1'b0;
                        state    <= GAP;
                    end
                end
                GAP: begin
                    if (gap_end) begin
                        if (last_tap) begin
                            state       <= DONE;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                            filt_resetn <= 1'b1;
                        end else begin
                            addr    <= addr + 1'b1;
                            s_ready <= 1'b1;
                            state   <= FETCH;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FIR_COEF_CHECKSUM_EN
    always_ff @(posedge clk_fast) begin
        if (!resetn) begin
            csum <= '0;
        end else if (start && !busy) begin
            csum <= '0;
        end else if (hs) begin
            csum <= csum + (CW+AW)'(s_data);
        end
    end
`endif

endmodule

// File: tb/tb_fir_coef_loader.sv
// Directed bench for fir_coef_loader: small NTAPS=4 instance plus a full-size
// NTAPS=2048 instance running its load in parallel.
`timescale 1ns/1ps
module tb_fir_coef_loader;
    import fir_pkg::*;

    localparam int CW   = 20;
    localparam int AW   = 11;
    localparam int PACE = 10;
    localparam int NT   = 4;
    localparam int NF   = 2048;

    typedef struct {
        int            dt;
        logic [AW-1:0] addr;
        logic [CW-1:0] cin;
    } vec_t;

    typedef struct {
        int            t;
        logic [AW-1:0] addr;
        logic [CW-1:0] cin;
        logic          vin;
    } ev_t;

    logic clk_fast = 1'b0;
    always #5 clk_fast = ~clk_fast;

    logic          resetn, start, s_valid, s_ready;
    logic          CLOAD, valid_in, filt_resetn, busy, done;
    logic [CW-1:0] s_data, CIN;
    logic [AW-1:0] CADDR;

    logic          rst_f, start_f, sv_f, sr_f;
    logic          cl_f, vi_f, fr_f, busy_f, done_f;
    logic [CW-1:0] sd_f, cin_f;
    logic [AW-1:0] caddr_f;

`ifdef FIR_COEF_CHECKSUM_EN
    logic [CW+AW-1:0] csum, csum_f;
`endif

    fir_coef_loader #(.NTAPS(NT), .CW(CW), .AW(AW), .PACE(PACE)) dut (
        .clk_fast    (clk_fast),
        .resetn      (resetn),
        .start       (start),
        .s_valid     (s_valid),
        .s_data      (s_data),
        .s_ready     (s_ready),
        .CIN         (CIN),
        .CADDR       (CADDR),
        .CLOAD       (CLOAD),
        .valid_in    (valid_in),
        .filt_resetn (filt_resetn),
        .busy        (busy),
        .done        (done)
`ifdef FIR_COEF_CHECKSUM_EN
        ,
        .csum        (csum)
`endif
    );

    fir_coef_loader #(.NTAPS(NF), .CW(CW), .AW(AW), .PACE(PACE)) dut_full (
        .clk_fast    (clk_fast),
        .resetn      (rst_f),
        .start       (start_f),
        .s_valid     (sv_f),
        .s_data      (sd_f),
        .s_ready     (sr_f),
        .CIN         (cin_f),
        .CADDR       (caddr_f),
        .CLOAD       (cl_f),
        .valid_in    (vi_f),
        .filt_resetn (fr_f),
        .busy        (busy_f),
        .done        (done_f)
`ifdef FIR_COEF_CHECKSUM_EN
        ,
        .csum        (csum_f)
`endif
    );

    int errs = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Cycle counter and event recorder, sampled mid-cycle.
    int  tcnt = 0;
    ev_t rec[$];
    int  drise[$];
    int  frise[$];
    int  vin_bad = 0;
    logic done_q = 1'b0;
    logic fr_q = 1'b0;

    always @(negedge clk_fast) begin
        if (CLOAD === 1'b1) rec.push_back('{tcnt, CADDR, CIN, valid_in});
        if (valid_in !== CLOAD && resetn === 1'b1) vin_bad++;
        if (done === 1'b1 && done_q !== 1'b1) drise.push_back(tcnt);
        if (filt_resetn === 1'b1 && fr_q !== 1'b1) frise.push_back(tcnt);
        done_q = done;
        fr_q = filt_resetn;
        tcnt++;
    end

    // Coefficient source for the small instance; hold window forces a stall.
    logic [CW-1:0] src[$];
    int hs_lo = 0;
    int hs_hi = 0;

    initial begin
        s_valid = 1'b0;
        s_data  = '0;
        forever begin
            @(posedge clk_fast);
            if (s_valid && s_ready) void'(src.pop_front());
            #1;
            s_valid = (src.size() > 0) && !(tcnt >= hs_lo && tcnt < hs_hi);
            s_data  = (src.size() > 0) ? src[0] : '0;
        end
    end

    // Full-size source: s_data equals the handshake index.
    int nf = 0;
    initial begin
        sv_f = 1'b0;
        sd_f = '0;
        forever begin
            @(posedge clk_fast);
            if (sv_f && sr_f) nf++;
            #1;
            sv_f = 1'b1;
            sd_f = CW'(nf);
        end
    end

    int fcount = 0;
    int fbad = 0;
    logic [AW-1:0] flast_a = '0;
    logic [CW-1:0] flast_d = '0;

    always @(negedge clk_fast) begin
        if (cl_f === 1'b1) begin
            if (caddr_f != fcount[AW-1:0] || cin_f != fcount[CW-1:0] || !vi_f) fbad++;
            flast_a = caddr_f;
            flast_d = cin_f;
            fcount++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_fast);
        #1;
    endtask

    vec_t basic[NT], stall[NT], reload[NT], cur[NT];

    task automatic check_load(input string tag, input int t0, input int dt_done);
        ev_t got[$];
        int dr, fr;
        foreach (rec[i]) if (rec[i].t >= t0) got.push_back(rec[i]);
        chk({tag, " strobe count"}, got.size(), NT);
        for (int i = 0; i < NT && i < got.size(); i++) begin
            chk($sformatf("%s strobe%0d time", tag, i), got[i].t - t0, cur[i].dt);
            chk($sformatf("%s strobe%0d CADDR", tag, i), got[i].addr, cur[i].addr);
            chk($sformatf("%s strobe%0d CIN", tag, i), got[i].cin, cur[i].cin);
        end
        dr = -1;
        fr = -1;
        foreach (drise[i]) if (drise[i] >= t0 && dr < 0) dr = drise[i] - t0;
        foreach (frise[i]) if (frise[i] >= t0 && fr < 0) fr = frise[i] - t0;
        chk({tag, " done time"}, dr, dt_done);
        chk({tag, " filt_resetn time"}, fr, dt_done);
    endtask

    int t0;
    int nlate;

    initial begin
        resetn  = 1'b0;
        start   = 1'b0;
        rst_f   = 1'b0;
        start_f = 1'b0;

        for (int i = 0; i < NT; i++) begin
            basic[i]  = '{2 + 10 * i, AW'(i), CW'(11 * (i + 1))};
            reload[i] = '{2 + 10 * i, AW'(i), CW'(9 + i)};
            stall[i]  = '{(i < 2) ? 2 + 10 * i : 27 + 10 * i, AW'(i), CW'(11 * (i + 1))};
        end

        cyc(3);
        chk("reset outputs", {s_ready, CIN, CADDR, CLOAD, valid_in, filt_resetn, busy, done}, '0);
        resetn = 1'b1;
        rst_f  = 1'b1;
        cyc(1);
        start_f = 1'b1;
        cyc(1);
        start_f = 1'b0;

        // Basic load with continuously valid source
        src = '{20'd11, 20'd22, 20'd33, 20'd44};
        cyc(1);
        start = 1'b1;
        t0 = tcnt;
        cyc(1);
        start = 1'b0;
        chk("basic busy after start", busy, 1);
        chk("basic s_ready in FETCH", s_ready, 1);
        cyc(60);
        chk("basic done level", done, 1);
        chk("basic busy cleared", busy, 0);
        chk("basic CADDR held", CADDR, 3);
        chk("basic CIN held", CIN, 44);
        cur = basic;
        check_load("basic", t0, 42);

        // Data offered while DONE stays pending upstream
        src.push_back(20'd55);
        cyc(5);
        chk("DONE s_ready", s_ready, 0);
        chk("DONE data pending", src.size(), 1);

        // Restart from DONE, stalled third coefficient, ignored mid-load start
        src = '{20'd11, 20'd22, 20'd33, 20'd44};
        start = 1'b1;
        t0 = tcnt;
        hs_lo = t0 + 21;
        hs_hi = t0 + 46;
        cyc(1);
        start = 1'b0;
        chk("restart filt_resetn", filt_resetn, 0);
        chk("restart done", done, 0);
        chk("restart busy", busy, 1);
        cyc(13);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(75);
        cur = stall;
        check_load("stall", t0, 67);

        // Reset mid-load after the second strobe
        src = '{20'd5, 20'd6, 20'd7, 20'd8};
        start = 1'b1;
        t0 = tcnt;
        cyc(1);
        start = 1'b0;
        cyc(13);
        resetn = 1'b0;
        cyc(1);
        chk("midreset outputs", {s_ready, CIN, CADDR, CLOAD, valid_in, filt_resetn, busy, done}, '0);
        src.delete();
        cyc(1);
        resetn = 1'b1;
        cyc(20);
        nlate = 0;
        foreach (rec[i]) if (rec[i].t >= t0 + 14) nlate++;
        chk("midreset no strobe", nlate, 0);

        src = '{20'd9, 20'd10, 20'd11, 20'd12};
        start = 1'b1;
        t0 = tcnt;
        cyc(1);
        start = 1'b0;
        cyc(60);
        cur = reload;
        check_load("reload", t0, 42);
        chk("valid_in tracks CLOAD", vin_bad, 0);

`ifdef FIR_COEF_CHECKSUM_EN
        chk("csum reload", csum, 42);
        src = '{20'd1, 20'd2, 20'd3, 20'hFFFFF};
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(60);
        chk("csum done", done, 1);
        chk("csum value", csum, 31'h100005);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        chk("csum cleared", csum, 0);
`endif

        // Full-size load
        for (int i = 0; i < 25000 && done_f !== 1'b1; i++) cyc(1);
        chk("full done", done_f, 1);
        cyc(20);
        chk("full strobe count", fcount, NF);
        chk("full last CADDR", flast_a, NF - 1);
        chk("full last CIN", flast_d, NF - 1);
        chk("full sequence errors", fbad, 0);
        chk("full filt_resetn", fr_f, 1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
